// File: rtl/wi23_defs.sv
// Shared definitions for the wi23 MMIO path: access granularity, bridge states
// and the default peripheral slot map.
package wi23_defs;

   typedef enum logic [1:0] {
      GRAN_WORD = 2'b00,
      GRAN_BYTE = 2'b01,
      GRAN_HALF = 2'b10
   } gran_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP
   } bridge_state_e;

   localparam int MMIO_NUM_SLOTS = 4;
   localparam int SLOT_VGA       = 0;
   localparam int SLOT_PS2       = 1;
   localparam int SLOT_TIMER     = 2;
   localparam int SLOT_UART      = 3;

   localparam logic [31:0] VGA_BASE   = 32'h0000_8000;
   localparam logic [31:0] VGA_MASK   = 32'hFFFF_C000;
   localparam logic [31:0] PS2_BASE   = 32'h0000_C000;
   localparam logic [31:0] PS2_MASK   = 32'hFFFF_FF00;
   localparam logic [31:0] TIMER_BASE = 32'h0000_C100;
   localparam logic [31:0] TIMER_MASK = 32'hFFFF_FF00;
   localparam logic [31:0] UART_BASE  = 32'h0000_C200;
   localparam logic [31:0] UART_MASK  = 32'hFFFF_FF00;

   // Packed with slot 0 in the least significant word.
   localparam logic [MMIO_NUM_SLOTS*32-1:0] MMIO_SLOT_BASE =
      {UART_BASE, TIMER_BASE, PS2_BASE, VGA_BASE};
   localparam logic [MMIO_NUM_SLOTS*32-1:0] MMIO_SLOT_MASK =
      {UART_MASK, TIMER_MASK, PS2_MASK, VGA_MASK};

endpackage

// File: rtl/mmio_lane_steer.sv
// Big-endian lane steering: byte 0 sits in bits [31:24]. Produces the shift,
// byte enables and read mask for one access, plus a flag for unusable accesses.
module mmio_lane_steer
   import wi23_defs::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  gran,
   output logic [4:0]  shift,
   output logic [3:0]  be,
   output logic [31:0] rmask,
   output logic        misalign
);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      shift    = 5'd0;
      be       = 4'b0000;
      rmask    = 32'h0;
      misalign = 1'b0;
      case (gran)
         GRAN_WORD: begin
            be       = 4'b1111;
            rmask    = 32'hFFFF_FFFF;
            misalign = (addr_lo != 2'b00);
         end
         GRAN_BYTE: begin
            shift = {~addr_lo, 3'b000};
            be    = 4'b1000 >> addr_lo;
            rmask = 32'h0000_00FF;
         end
         GRAN_HALF: begin
            rmask = 32'h0000_FFFF;
            case (addr_lo)
               2'b00:   begin shift = 5'd16; be = 4'b1100; end
               2'b01:   begin shift = 5'd8;  be = 4'b0110; end
               2'b10:   begin shift = 5'd0;  be = 4'b0011; end
               default: misalign = 1'b1;
            endcase
         end
         // The illegal granularity is reported through the same flag.
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/mmio_bridge.sv
// Handshaked MMIO bridge: decodes a processor access onto one of NUM_SLOTS
// peripheral windows, steers lanes, and returns data or an error with bounded latency.
module mmio_bridge
   import wi23_defs::*;
#(
   parameter int                        NUM_SLOTS = 4,
   parameter int                        DATA_W    = 32,
   parameter int                        ADDR_W    = 32,
   parameter int                        TIMEOUT   = 16,
   parameter logic [NUM_SLOTS*32-1:0]   SLOT_BASE = {NUM_SLOTS{32'h0}},
   parameter logic [NUM_SLOTS*32-1:0]   SLOT_MASK = {NUM_SLOTS{32'hFFFF_FF00}}
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid_i,
   output logic                        req_ready_o,
   input  logic [ADDR_W-1:0]           req_addr_i,
   input  logic                        req_write_i,
   input  logic [1:0]                  req_gran_i,
   input  logic [DATA_W-1:0]           req_wdata_i,
   output logic                        rsp_valid_o,
   output logic [DATA_W-1:0]           rsp_rdata_o,
   output logic                        rsp_err_o,
   output logic [ADDR_W-1:0]           err_addr_o,
   output logic [NUM_SLOTS-1:0]        slot_req_o,
   output logic [ADDR_W-1:0]           slot_addr_o,
   output logic [3:0]                  slot_be_o,
   output logic [DATA_W-1:0]           slot_wdata_o,
   input  logic [NUM_SLOTS-1:0]        slot_ack_i,
   input  logic [NUM_SLOTS*DATA_W-1:0] slot_rdata_i
);

   localparam int SEL_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   bridge_state_e     state;
   logic [SEL_W-1:0]  sel_q;
   logic [4:0]        rd_shift_q;
   logic [31:0]       rd_mask_q;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [CNT_W-1:0]  tcount;

   logic              hit;
   logic [SEL_W-1:0]  hit_idx;
   logic [4:0]        shift;
   logic [3:0]        be;
   logic [31:0]       rmask;
   logic              misalign;

   assign req_ready_o = (state == ST_IDLE);

   // Walk from the top down so the lowest-index match is the one that sticks.
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if ((req_addr_i & SLOT_MASK[i*32 +: ADDR_W]) == SLOT_BASE[i*32 +: ADDR_W]) begin
            hit     = 1'b1;
            hit_idx = SEL_W'(i);
         end
      end
   end

   mmio_lane_steer u_steer (
      .addr_lo  (req_addr_i[1:0]),
      .gran     (req_gran_i),
      .shift    (shift),
      .be       (be),
      .rmask    (rmask),
      .misalign (misalign)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         sel_q        <= '0;
         rd_shift_q   <= '0;
         rd_mask_q    <= '0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         tcount       <= '0;
         rsp_valid_o  <= 1'b0;
         rsp_rdata_o  <= '0;
         rsp_err_o    <= 1'b0;
         err_addr_o   <= '0;
         slot_req_o   <= '0;
         slot_addr_o  <= '0;
         slot_be_o    <= '0;
         slot_wdata_o <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid_i) begin
                  addr_q <= req_addr_i;
                  if (!hit || misalign) begin
                     state       <= ST_RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= 1'b1;
                     rsp_rdata_o <= '0;
                     err_addr_o  <= req_addr_i;
                  end else begin
                     state        <= ST_WAIT;
                     sel_q        <= hit_idx;
                     rd_shift_q   <= shift;
                     rd_mask_q    <= rmask;
                     write_q      <= req_write_i;
                     tcount       <= '0;
                     slot_req_o   <= NUM_SLOTS'(1) << hit_idx;
                     slot_addr_o  <= req_addr_i & ~ADDR_W'(3);
                     slot_be_o    <= req_write_i ? be : 4'b0000;
                     slot_wdata_o <= req_write_i ? (req_wdata_i << shift) : '0;
                  end
               end
            end
            ST_WAIT: begin
               // Ack is checked before the timeout so an ack on the last cycle still succeeds.
               if (slot_ack_i[sel_q]) begin
                  state       <= ST_RESP;
                  slot_req_o  <= '0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b0;
                  rsp_rdata_o <= write_q ? '0
                               : ((slot_rdata_i[sel_q*DATA_W +: DATA_W] >> rd_shift_q) & rd_mask_q);
               end else if (tcount == CNT_W'(TIMEOUT - 1)) begin
                  state       <= ST_RESP;
                  slot_req_o  <= '0;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= '0;
                  err_addr_o  <= addr_q;
               end else begin
                  tcount <= tcount + CNT_W'(1);
               end
            end
            ST_RESP: begin
               state       <= ST_IDLE;
               rsp_valid_o <= 1'b0;
               rsp_err_o   <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mmio_bridge.md
# mmio_bridge

Parametrised memory-mapped I/O bridge between the processor data port and `NUM_SLOTS` peripheral slots (VGA, PS/2, timer, UART, …). It decodes each access against per-slot base/mask windows and steers byte/half-word lanes with byte 0 in the high lane. It forwards the access over a req/ack handshake, and returns zero-extended read data or an error on unmapped, misaligned or timed-out accesses. It replaces the combinational peripheral mux in the top level with a handshaked, bounded-latency path.

## Interface
- `NUM_SLOTS`, 4: number of peripheral slots.
- `DATA_W`, 32: data width; fixed at 32 for lane steering.
- `ADDR_W`, 32: address width.
- `TIMEOUT`, 16: maximum cycles `slot_req_o` is held awaiting ack; must be ≥1.
- `SLOT_BASE`, `{NUM_SLOTS{32'h0}}`: packed per-slot base addresses.
- `SLOT_MASK`, `{NUM_SLOTS{32'hFFFF_FF00}}`: packed per-slot masks. A slot hits when `(addr & MASK) == BASE`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid_i` in 1: processor request valid.
- `req_ready_o` out 1: bridge idle and able to accept a request.
- `req_addr_i` in `ADDR_W`: byte address.
- `req_write_i` in 1: 1 = write, 0 = read.
- `req_gran_i` in 2: granularity. 00 = word, 01 = byte, 10 = half, 11 = illegal.
- `req_wdata_i` in `DATA_W`: write data, right-justified.
- `rsp_valid_o` out 1: one-cycle response strobe.
- `rsp_rdata_o` out `DATA_W`: read data, zero-extended and right-justified.
- `rsp_err_o` out 1: error flag, qualified by `rsp_valid_o`.
- `err_addr_o` out `ADDR_W`: sticky address of the most recent errored request.
- `slot_req_o` out `NUM_SLOTS`: one-hot request to a slot.
- `slot_addr_o` out `ADDR_W`: registered word-aligned address (`addr & ~3`).
- `slot_be_o` out 4: byte enables; all zero on reads.
- `slot_wdata_o` out `DATA_W`: lane-steered write data.
- `slot_ack_i` in `NUM_SLOTS`: slot completion.
- `slot_rdata_i` in `NUM_SLOTS*DATA_W`: packed slot read data, valid with ack.

## Operation
- FSM states:
  - IDLE: `req_ready_o`=1.
  - WAIT: `slot_req_o` asserted.
  - RESP: `rsp_valid_o`=1 for exactly one cycle, then return to IDLE.
- Request accepted on `req_valid_i & req_ready_o` in IDLE.
- Decode: lowest-index matching slot wins.
- Error on accept, going straight to RESP with err=1 and no slot request:
  - no slot matches;
  - gran=11;
  - word access with `addr[1:0]`≠0;
  - half access with `addr[1:0]`=11.
- Byte lane steering:
  - write data shifted left by `{~a[1:0],3'b0}`;
  - be = 1000, 0100, 0010, 0001 for a = 00, 01, 10, 11.
- Half lane steering:
  - a=00: shift 16, be 1100;
  - a=01: shift 8, be 0110;
  - a=10: shift 0, be 0011.
- Word: shift 0, be 1111.
- Read path: captured slot data shifted right by the same amount, then masked to 0xFF (byte), 0xFFFF (half) or unmasked (word).
- Ack is sampled only for the active slot in WAIT. On ack: capture data, drop `slot_req_o` next cycle, go to RESP with err=0.
- Timeout: counter cleared on entry to WAIT and incremented each WAIT cycle without ack. With no ack when count==`TIMEOUT`-1, go to RESP with err=1 and `rsp_rdata_o`=0.
- Ack on the last allowed cycle counts as success.
- Acks outside WAIT, or from non-selected slots, are ignored.
- Any error loads `err_addr_o` with the request address; it is never cleared except by reset.
- On write responses, `rsp_rdata_o` = 0.

## Timing
- Reset values:
  - state IDLE, so `req_ready_o`=1;
  - `rsp_valid_o`, `rsp_err_o`, `rsp_rdata_o`, `err_addr_o`, `slot_req_o`, `slot_be_o`, `slot_addr_o` and `slot_wdata_o` all 0.
- All `slot_*` outputs and `rsp_*` outputs are registered.
- Latency, with accept at cycle 0:
  - `slot_req_o` high from cycle 1;
  - ack at cycle k ≥1 gives `rsp_valid_o` at k+1;
  - decode error gives `rsp_valid_o` at cycle 1;
  - timeout gives `slot_req_o` high for exactly `TIMEOUT` cycles (1..`TIMEOUT`) and `rsp_valid_o` at `TIMEOUT`+1.
- No response backpressure.
- Next accept is possible the cycle after RESP, so back-to-back throughput is one access per 3 cycles minimum.
- Reset asserted mid-transaction: asynchronously returns to IDLE, drops `slot_req_o`, and no response is issued.

## Structure
- `wi23_defs` gains:
  - `gran_e` (GRAN_WORD=00, GRAN_BYTE=01, GRAN_HALF=10);
  - slot index constants (SLOT_VGA, SLOT_PS2, SLOT_TIMER, SLOT_UART);
  - their base/mask localparams.
- One combinational sub-module, `mmio_lane_steer`: address bits and gran in; write shift, byte enables, read shift/mask and misalign flag out. Instantiated once, used by both the write and read paths.

## Test plan
- Read, word, slot 1 (base 0x0000_C000), slot acks at cycle 1 with 0xDEADBEEF -> `rsp_valid_o` at cycle 2, rdata 0xDEADBEEF, err 0.
- Write byte 0xA5 to addr 0xC001 -> `slot_be_o`=0100, `slot_wdata_o`=0x00A5_0000, `slot_addr_o`=0xC000.
- Read half at 0xC001, slot data 0x1122_3344 -> rdata 0x0000_2233.
- Unmapped addr 0x8000_0000, plus word at 0xC002 -> each gives err at cycle 1, no `slot_req_o`, and `err_addr_o` equals the second address.
- No ack with `TIMEOUT`=16 -> `slot_req_o` high for 16 cycles, err at cycle 17. Then repeat with ack on cycle 16 -> success.
- Reset pulsed during WAIT -> `slot_req_o` 0 immediately, `req_ready_o`=1, no `rsp_valid_o`.
